// File: rtl/sys_bridge_n_if.sv
// CPU data port and device array signals of the system bridge, bundled for
// port connection. The master side is the CPU plus devices; the slave side is the bridge.
interface sys_bridge_n_if #(
  parameter int NDEV = 2
);
  logic                 pr_req;
  logic [29:0]          pr_addr;
  logic [31:0]          pr_wd;
  logic                 pr_we;
  logic                 pr_ready;
  logic [31:0]          pr_rd;
  logic                 pr_err;
  logic [31:0]          err_addr;
  logic [29:0]          dev_addr;
  logic [31:0]          dev_wd;
  logic [NDEV-1:0]      dev_req;
  logic [NDEV-1:0]      dev_we;
  logic [NDEV-1:0]      dev_ready;
  logic [32*NDEV-1:0]   dev_rd;
  logic [NDEV-1:0]      dev_irq;
  logic [NDEV-1:0]      irq_out;

  modport master (
    output pr_req, pr_addr, pr_wd, pr_we, dev_ready, dev_rd, dev_irq,
    input  pr_ready, pr_rd, pr_err, err_addr, dev_addr, dev_wd, dev_req, dev_we, irq_out
  );

  modport slave (
    input  pr_req, pr_addr, pr_wd, pr_we, dev_ready, dev_rd, dev_irq,
    output pr_ready, pr_rd, pr_err, err_addr, dev_addr, dev_wd, dev_req, dev_we, irq_out
  );
endinterface

// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: decodes NDEV equal-stride windows, runs a req/ready
// handshake with timeout, reports bus errors and forwards interrupts registered.
module sys_bridge_n #(
  parameter int          NDEV       = 2,
  parameter logic [31:0] BASE       = 32'h0000_7f00,
  parameter int          STRIDE     = 16,
  parameter int          REGS       = 3,
  parameter logic [31:0] DEFAULT_RD = 32'h2333_3333,
  parameter int          TIMEOUT    = 15
) (
  input  logic           clk,
  input  logic           reset,
  sys_bridge_n_if.slave  bus
);

  localparam int              SW       = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NDEV-1:0] ONE_HOT0 = NDEV'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [SW-1:0]   sel_r, sel_s, slot_s;
  logic            we_r, we_s;
  logic [NDEV-1:0] hit_vec_s, slot_onehot_s;
  logic [NDEV-1:0] dev_req_r, dev_req_s, dev_we_r, dev_we_s, irq_r;
  logic [29:0]     dev_addr_r, dev_addr_s;
  logic [31:0]     dev_wd_r, dev_wd_s, pr_rd_r, pr_rd_s, err_addr_r, err_addr_s;
  logic            pr_ready_r, pr_ready_s, pr_err_r, pr_err_s;
  logic [31:0]     req_byte_s, sel_rd_s;

  assign req_byte_s    = {bus.pr_addr, 2'b00};
  assign slot_onehot_s = ONE_HOT0 << slot_s;
  assign sel_rd_s      = bus.dev_rd[32*int'(sel_r) +: 32];

  for (genvar g = 0; g < NDEV; g++) begin : g_dec
    localparam logic [31:0] LO = BASE + 32'(g * STRIDE);
    localparam logic [31:0] HI = LO + 32'(4 * REGS);
    assign hit_vec_s[g] = (req_byte_s >= LO) && (req_byte_s < HI);
  end

  // Windows never overlap, so OR-ing the indices of hit slots yields the single hit.
  always_comb begin
    slot_s = {SW{1'b0}};
    for (int i = 0; i < NDEV; i++) begin
      slot_s = slot_s | (hit_vec_s[i] ? SW'(i) : {SW{1'b0}});
    end
  end

  // Next-state and next-output logic; device strobes are precomputed so they leave a flop.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    sel_s      = sel_r;
    we_s       = we_r;
    dev_addr_s = dev_addr_r;
    dev_wd_s   = dev_wd_r;
    pr_rd_s    = pr_rd_r;
    pr_err_s   = pr_err_r;
    err_addr_s = err_addr_r;
    pr_ready_s = 1'b0;
    dev_req_s  = {NDEV{1'b0}};
    dev_we_s   = {NDEV{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.pr_req) begin
          dev_addr_s = bus.pr_addr;
          dev_wd_s   = bus.pr_wd;
          we_s       = bus.pr_we;
          sel_s      = slot_s;
          if (|hit_vec_s) begin
            state_s   = ST_BUSY;
            cnt_s     = {CW{1'b0}};
            dev_req_s = slot_onehot_s;
            dev_we_s  = bus.pr_we ? slot_onehot_s : {NDEV{1'b0}};
          end else begin
            state_s    = ST_RESP;
            pr_ready_s = 1'b1;
            pr_rd_s    = DEFAULT_RD;
            pr_err_s   = 1'b1;
            err_addr_s = req_byte_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (bus.dev_ready[sel_r]) begin
          state_s    = ST_RESP;
          pr_ready_s = 1'b1;
          pr_rd_s    = we_r ? 32'h0000_0000 : sel_rd_s;
          pr_err_s   = 1'b0;
        end else if (cnt_r == TMO_LAST) begin
          state_s    = ST_RESP;
          pr_ready_s = 1'b1;
          pr_rd_s    = DEFAULT_RD;
          pr_err_s   = 1'b1;
          err_addr_s = {dev_addr_r, 2'b00};
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
          dev_req_s = dev_req_r;
          dev_we_s  = dev_we_r;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; irq forwarding runs independently of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      sel_r      <= {SW{1'b0}};
      we_r       <= 1'b0;
      dev_addr_r <= 30'h0000_0000;
      dev_wd_r   <= 32'h0000_0000;
      pr_rd_r    <= 32'h0000_0000;
      pr_err_r   <= 1'b0;
      err_addr_r <= 32'h0000_0000;
      pr_ready_r <= 1'b0;
      dev_req_r  <= {NDEV{1'b0}};
      dev_we_r   <= {NDEV{1'b0}};
      irq_r      <= {NDEV{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      sel_r      <= sel_s;
      we_r       <= we_s;
      dev_addr_r <= dev_addr_s;
      dev_wd_r   <= dev_wd_s;
      pr_rd_r    <= pr_rd_s;
      pr_err_r   <= pr_err_s;
      err_addr_r <= err_addr_s;
      pr_ready_r <= pr_ready_s;
      dev_req_r  <= dev_req_s;
      dev_we_r   <= dev_we_s;
      irq_r      <= bus.dev_irq;
    end
  end

  assign bus.pr_ready = pr_ready_r;
  assign bus.pr_rd    = pr_rd_r;
  assign bus.pr_err   = pr_err_r;
  assign bus.err_addr = err_addr_r;
  assign bus.dev_addr = dev_addr_r;
  assign bus.dev_wd   = dev_wd_r;
  assign bus.dev_req  = dev_req_r;
  assign bus.dev_we   = dev_we_r;
  assign bus.irq_out  = irq_r;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Bench for sys_bridge_n: transaction-level latency/response model driven by
// random and directed transfers, checked every cycle by one compare process.
module tb_sys_bridge_n;
  localparam int          NDEV       = 2;
  localparam logic [31:0] BASE       = 32'h0000_7f00;
  localparam int          STRIDE     = 16;
  localparam int          REGS       = 3;
  localparam logic [31:0] DEFAULT_RD = 32'h2333_3333;
  localparam int          TIMEOUT    = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sys_bridge_n_if #(.NDEV(NDEV)) bus ();

  sys_bridge_n #(
    .NDEV(NDEV), .BASE(BASE), .STRIDE(STRIDE), .REGS(REGS),
    .DEFAULT_RD(DEFAULT_RD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // model state and per-cycle expectations
  logic            exp_valid;
  logic            exp_ready, exp_err;
  logic [31:0]     exp_rd, exp_err_addr, exp_dwd;
  logic [NDEV-1:0] exp_req, exp_we, irq_hist;
  logic [29:0]     exp_daddr;
  logic [29:0]     m_addr;
  logic [31:0]     m_wd, m_err_addr;
  int              cur_k;

  // observations used by directed literal checks
  int              obs_k, obs_wecnt, obs_reqany, rdy_cnt;
  logic [31:0]     obs_rd;
  logic            obs_err;
  logic [NDEV-1:0] obs_req1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("pr_ready", bus.pr_ready, exp_ready);
      if (exp_ready) begin
        check("pr_rd", bus.pr_rd, exp_rd);
        check("pr_err", bus.pr_err, exp_err);
      end
      check("err_addr", bus.err_addr, exp_err_addr);
      check("dev_req", bus.dev_req, exp_req);
      check("dev_we", bus.dev_we, exp_we);
      check("dev_addr", bus.dev_addr, exp_daddr);
      check("dev_wd", bus.dev_wd, exp_dwd);
      check("irq_out", bus.irq_out, irq_hist);
    end
    if (bus.pr_ready) begin
      obs_k   = cur_k;
      obs_rd  = bus.pr_rd;
      obs_err = bus.pr_err;
      rdy_cnt++;
    end
    if (cur_k == 1) obs_req1 = bus.dev_req;
    if (bus.dev_we == 2'b01 && bus.dev_wd == 32'h0000_1234) obs_wecnt++;
    if (bus.dev_req != '0) obs_reqany++;
    irq_hist = reset ? '0 : bus.dev_irq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obs_clear();
    obs_k = -1; obs_wecnt = 0; obs_reqany = 0; rdy_cnt = 0;
    obs_rd = '0; obs_err = 1'b0; obs_req1 = '0;
  endtask

  task automatic model_reset();
    m_addr = '0; m_wd = '0; m_err_addr = '0;
    exp_ready = 1'b0; exp_req = '0; exp_we = '0;
    exp_daddr = '0; exp_dwd = '0; exp_err_addr = '0;
  endtask

  task automatic rand_inputs();
    bus.pr_addr   = 30'($urandom);
    bus.pr_wd     = $urandom;
    bus.pr_we     = 1'($urandom);
    bus.dev_ready = NDEV'($urandom);
    bus.dev_irq   = NDEV'($urandom);
  endtask

  function automatic int model_slot(input logic [31:0] a);
    logic [31:0] lo;
    for (int i = 0; i < NDEV; i++) begin
      lo = BASE + 32'(i * STRIDE);
      if (a >= lo && a < lo + 32'(4 * REGS)) return i;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cur_k = 0;
      rand_inputs();
      bus.pr_req = 1'b0;
      exp_ready = 1'b0; exp_req = '0; exp_we = '0;
      exp_daddr = m_addr; exp_dwd = m_wd; exp_err_addr = m_err_addr;
    end
  endtask

  // One transfer: device answers after w wait cycles (ready in BUSY cycle w+1).
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input int w, input logic [31:0] rd_val, input logic req_in_resp);
    int slot, rcyc;
    logic [NDEV-1:0] oh;
    slot = model_slot(a);
    rcyc = (slot < 0) ? 1 : ((w < TIMEOUT) ? w + 2 : TIMEOUT + 1);
    oh   = (slot < 0) ? '0 : NDEV'(1) << slot;
    tick();
    cur_k = 0;
    rand_inputs();
    bus.pr_req = 1'b1; bus.pr_addr = a[31:2]; bus.pr_wd = wd; bus.pr_we = we;
    for (int i = 0; i < NDEV; i++) bus.dev_rd[32*i +: 32] = $urandom;
    if (slot >= 0) bus.dev_rd[32*slot +: 32] = rd_val;
    exp_ready = 1'b0; exp_req = '0; exp_we = '0;
    exp_daddr = m_addr; exp_dwd = m_wd; exp_err_addr = m_err_addr;
    m_addr = a[31:2]; m_wd = wd;
    for (int k = 1; k <= rcyc; k++) begin
      tick();
      cur_k = k;
      rand_inputs();
      bus.pr_req = (k == rcyc) ? req_in_resp : 1'($urandom);
      if (slot >= 0) bus.dev_ready[slot] = (k == w + 1);
      if (k < rcyc) begin
        exp_ready = 1'b0; exp_req = oh; exp_we = we ? oh : '0;
      end else begin
        exp_ready = 1'b1; exp_req = '0; exp_we = '0;
        if (slot < 0 || w >= TIMEOUT) begin
          exp_rd = DEFAULT_RD; exp_err = 1'b1; m_err_addr = a;
        end else begin
          exp_rd = we ? 32'h0 : rd_val; exp_err = 1'b0;
        end
      end
      exp_daddr = m_addr; exp_dwd = m_wd; exp_err_addr = m_err_addr;
    end
  endtask

  initial begin
    logic [31:0] a, r;
    int w, sel;
    reset = 1'b1; exp_valid = 1'b0; cur_k = 0;
    bus.pr_req = 1'b0; bus.pr_addr = '0; bus.pr_wd = '0; bus.pr_we = 1'b0;
    bus.dev_ready = '0; bus.dev_rd = '0; bus.dev_irq = '0;
    model_reset(); obs_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_valid = 1'b1;
    idle(2);

    // asynchronous reset in the middle of a response cycle
    run_txn(32'h0000_7f3c, 1'b1, 32'h5a5a_0001, 0, 32'h0, 1'b0);
    exp_valid = 1'b0;
    check("t1_pre_ready", bus.pr_ready, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("t1_rst_ready", bus.pr_ready, 32'h0);
    check("t1_rst_rd", bus.pr_rd, 32'h0);
    check("t1_rst_err", bus.pr_err, 32'h0);
    check("t1_rst_err_addr", bus.err_addr, 32'h0);
    check("t1_rst_dev_addr", bus.dev_addr, 32'h0);
    check("t1_rst_dev_wd", bus.dev_wd, 32'h0);
    check("t1_rst_dev_req", bus.dev_req, 32'h0);
    check("t1_rst_dev_we", bus.dev_we, 32'h0);
    check("t1_rst_irq", bus.irq_out, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    exp_valid = 1'b1;
    idle(5);
    check("t1_idle_req", bus.dev_req, 32'h0);

    // hit read, zero wait
    obs_clear();
    run_txn(32'h0000_7f14, 1'b0, 32'h1111_2222, 0, 32'hCAFE_0001, 1'b0);
    idle(1);
    check("t2_req1", obs_req1, 32'h2);
    check("t2_lat", obs_k, 32'd2);
    check("t2_rd", obs_rd, 32'hCAFE_0001);
    check("t2_err", obs_err, 32'h0);

    // hit write, three wait states
    obs_clear();
    run_txn(32'h0000_7f00, 1'b1, 32'h0000_1234, 3, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    check("t3_lat", obs_k, 32'd5);
    check("t3_err", obs_err, 32'h0);
    check("t3_we_cycles", obs_wecnt, 32'd4);

    // miss in the gap between windows
    obs_clear();
    run_txn(32'h0000_7f0c, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    idle(1);
    check("t4_lat", obs_k, 32'd1);
    check("t4_rd", obs_rd, 32'h2333_3333);
    check("t4_err", obs_err, 32'h1);
    check("t4_err_addr", bus.err_addr, 32'h0000_7f0c);
    check("t4_no_req", obs_reqany, 32'd0);

    // timeout, then ready on the last BUSY cycle
    obs_clear();
    run_txn(32'h0000_7f10, 1'b0, 32'h0, 1000, 32'h1234_5678, 1'b0);
    idle(1);
    check("t5_to_lat", obs_k, 32'd16);
    check("t5_to_err", obs_err, 32'h1);
    check("t5_to_err_addr", bus.err_addr, 32'h0000_7f10);
    obs_clear();
    run_txn(32'h0000_7f10, 1'b0, 32'h0, 14, 32'h8765_4321, 1'b0);
    idle(1);
    check("t5_tie_lat", obs_k, 32'd16);
    check("t5_tie_err", obs_err, 32'h0);
    check("t5_tie_rd", obs_rd, 32'h8765_4321);

    // back-to-back with request held through the response cycle
    run_txn(32'h0000_7f14, 1'b0, 32'h0, 1, 32'hAAAA_0001, 1'b1);
    obs_clear();
    run_txn(32'h0000_7f04, 1'b0, 32'h0, 0, 32'hBBBB_0002, 1'b0);
    idle(1);
    check("t6_b2b_lat", obs_k, 32'd2);
    check("t6_b2b_rd", obs_rd, 32'hBBBB_0002);

    // interrupt forwarding
    tick(); bus.dev_irq = 2'b10;
    tick(); bus.dev_irq = 2'b01;
    check("t6_irq_a", bus.irq_out, 32'h2);
    tick();
    check("t6_irq_b", bus.irq_out, 32'h1);
    idle(1);

    // reset while BUSY
    exp_valid = 1'b0;
    obs_clear();
    tick();
    bus.pr_req = 1'b1; bus.pr_addr = 30'h0000_1fc4; bus.pr_we = 1'b0; bus.dev_ready = '0;
    tick(); bus.pr_req = 1'b0;
    tick(); tick();
    check("t6_busy_req", bus.dev_req, 32'h2);
    reset = 1'b1;
    #1;
    check("t6_rst_req", bus.dev_req, 32'h0);
    check("t6_rst_ready", bus.pr_ready, 32'h0);
    tick(); tick();
    reset = 1'b0;
    model_reset();
    exp_valid = 1'b1;
    idle(20);
    check("t6_no_resp", rdy_cnt, 32'd0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        r = $urandom;
        a = {r[31:2], 2'b00};
      end else begin
        a = 32'h0000_7ef8 + 32'(4 * $urandom_range(0, 14));
      end
      sel = $urandom_range(0, 9);
      if (sel < 6) w = $urandom_range(0, 4);
      else if (sel < 8) w = $urandom_range(12, 16);
      else w = $urandom_range(5, 30);
      run_txn(a, 1'($urandom), $urandom, w, $urandom, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
